// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags and non-power-of-2 depth.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         r_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
    $error("sync_fifo_flags: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] w_ptr, r_ptr;
  logic wr_acc, rd_acc;
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_THRESH);
  assign almost_empty = count <= CW'(AE_THRESH);
  always_ff @(posedge clk)
    if (wr_acc) mem[w_ptr] <= data_in;
  // Pointers wrap by explicit compare so any DEPTH works, not just powers of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) w_ptr <= (w_ptr == AW'(DEPTH - 1)) ? '0 : w_ptr + 1'b1;
      if (rd_acc) begin
        data_out <= mem[r_ptr];
        r_ptr    <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
      count <= count + CW'(wr_acc) - CW'(rd_acc);
    end
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en & full) | (overflow & ~err_clr);
      underflow <= (r_en & empty) | (underflow & ~err_clr);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO and successor to the basic counter-based sync FIFO.
- Adds an occupancy count output, programmable almost-full/almost-empty thresholds, non-power-of-2 depth support, and correct simultaneous read/write accounting.
- Used as the general-purpose buffer between same-clock pipeline stages.

Parameters:
- DATA_WIDTH, 8, data bus width in bits (>=1).
- DEPTH, 8, number of entries; any integer >=2, need not be a power of 2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request.
- data_out  out  DATA_WIDTH  read data, registered.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- err_clr  in  1  clears sticky error flags (optional feature only).
- overflow  out  1  sticky write-while-full flag (optional feature only).
- underflow  out  1  sticky read-while-empty flag (optional feature only).

Behaviour:
- Reset (rst_n low at a clk edge): w_ptr=0, r_ptr=0, count=0, data_out=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, almost_full=0, almost_empty=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the first post-reset read returns the first post-reset write.
- Accept rules:
  - wr_acc = w_en & !full
  - rd_acc = r_en & !empty
  - Both are evaluated on pre-edge flags.
- Write: on wr_acc, mem[w_ptr] <= data_in. w_ptr increments, wrapping from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- Read: on rd_acc, data_out <= mem[r_ptr] and r_ptr increments with the same wrap rule.
  - Latency: data is valid on data_out the cycle after the accepting edge.
  - data_out holds its value when no read is accepted.
- Count update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both, or neither: unchanged.
  - Count is driven only by accepted operations; rejected requests never alter count or pointers.
  - Width $clog2(DEPTH+1), so count==DEPTH is representable.
- Full + w_en + r_en: read accepted, write rejected, count becomes DEPTH-1.
- Empty + w_en + r_en: write accepted, read rejected (no fall-through), count becomes 1, data_out unchanged.
- Simultaneous read/write at 0<count<DEPTH: both accepted, including when r_ptr==w_ptr is impossible, i.e. pointers distinct.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered count only, with no input-to-output paths.
  - Each flag changes the cycle after the edge that changes count.
- Elaboration-time check: AF_THRESH in 1..DEPTH and AE_THRESH in 0..DEPTH-1; otherwise $error.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any edge with w_en & full.
  - underflow sets on any edge with r_en & empty.
  - Both are sticky until reset, or until an edge with err_clr=1.
  - Set has priority over err_clr in the same cycle.
- Undefined:
  - overflow and underflow are tied to 0 and err_clr is ignored.
  - Ports remain present so instantiations do not change.

Test Plan:
- DEPTH=8: reset, then write 0x01..0x08 on consecutive cycles -> count 1..8, full=1 after the 8th edge, almost_full=1 once count>=6, then w_en with 0x09 -> count stays 8, and 0x09 is never read.
- Read 8 back-to-back -> data_out 0x01..0x08, each one cycle after its accepting edge, empty=1 after the last, almost_empty=1 at count<=1. An extra r_en -> data_out holds 0x08.
- Full FIFO, w_en=r_en=1 for one cycle -> count 7, oldest word out, full=0. Empty FIFO, w_en=r_en=1 -> count 1, data_out unchanged.
- DEPTH=6: write/read 20 words streaming with count held at 3 (simultaneous read and write) -> in-order data, pointers wrap at 5->0, count stays 3.
- Reset asserted at count=5 -> next cycle count=0, empty=1, data_out=0; then write 0xAA and read it -> data_out=0xAA.
- With SYNC_FIFO_ERR_FLAGS_EN: write to full -> overflow=1 and held; err_clr together with another overflowing write -> overflow stays 1; err_clr alone -> 0. Read at empty -> underflow=1. Without the macro, both stay 0 throughout.
